// File: rtl/uc_pkg.sv
// uc_pkg: shared encodings for the uc controller (states, opcodes, ALU ops, mux selects, control word)
package uc_pkg;
  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD_A, S_LOAD_B, S_EXEC, S_IN_WAIT, S_OUT_WAIT, S_HALT
  } state_t;
  localparam logic [3:0] COP_ADD = 4'h0;
  localparam logic [3:0] COP_CMP = 4'h1;
  localparam logic [3:0] COP_MOV = 4'h2;
  localparam logic [3:0] COP_BEQ = 4'h3;
  localparam logic [3:0] COP_IN  = 4'h4;
  localparam logic [3:0] COP_OUT = 4'h5;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_A = 2'b10;
  localparam logic [1:0] MX_PC   = 2'b00;
  localparam logic [1:0] MX_ZERO = 2'b01;
  localparam logic [1:0] MX_SRC  = 2'b10;
  localparam logic [1:0] MX_DST  = 2'b11;
  typedef struct packed {
    logic [1:0] mx;
    logic [1:0] alu;
    logic le;
    logic pc_w;
    logic ir_w;
    logic a_w;
    logic b_w;
    logic fz_w;
    logic mx_memio;
    logic in_req;
    logic out_valid;
    logic halted;
  } ctrl_t;
endpackage

// File: rtl/uc_if.sv
// uc_if: controller/datapath bundle; master = controller (in: cop fz in_valid out_ready, out: control word), slave = datapath
interface uc_if;
  import uc_pkg::*;
  logic [3:0] cop;
  logic fz, in_valid, out_ready;
  logic mx1, mx0, alu_op1, alu_op0;
  logic le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio, in_req, out_valid, halted;
  modport master (
    input  cop, fz, in_valid, out_ready,
    output mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio, in_req, out_valid, halted
  );
  modport slave (
    output cop, fz, in_valid, out_ready,
    input  mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio, in_req, out_valid, halted
  );
endinterface

// File: rtl/uc.sv
// uc: multicycle control unit FSM; ports clk, rst_n (async active-low), bus (uc_if.master: cop/fz/handshakes in, control word out)
module uc
  import uc_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  uc_if.master bus
);
  state_t state;
  logic [3:0] cop_q;
  ctrl_t c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_INIT;
      cop_q <= COP_ADD;
    end else
      case (state)
        S_INIT:     state <= S_FETCH;
        S_FETCH:    state <= S_DECODE;
        S_DECODE: begin
          cop_q <= bus.cop;
          state <= (bus.cop == COP_ADD || bus.cop == COP_CMP || bus.cop == COP_MOV) ? S_LOAD_A :
                   bus.cop == COP_BEQ ? (bus.fz ? S_DECODE : S_FETCH) :
                   bus.cop == COP_IN  ? S_IN_WAIT :
                   bus.cop == COP_OUT ? S_OUT_WAIT : S_HALT;
        end
        S_LOAD_A:   state <= cop_q == COP_MOV ? S_EXEC : S_LOAD_B;
        S_LOAD_B:   state <= S_EXEC;
        S_EXEC:     state <= S_FETCH;
        S_IN_WAIT:  state <= bus.in_valid ? S_FETCH : S_IN_WAIT;
        S_OUT_WAIT: state <= bus.out_ready ? S_FETCH : S_OUT_WAIT;
        default:    state <= S_HALT;
      endcase
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mx = MX_PC;
        c.ir_w = 1'b1;
        c.pc_w = 1'b1;
      end
      S_DECODE:
        if (bus.cop == COP_BEQ && bus.fz) begin
          c.mx = MX_DST;
          c.ir_w = 1'b1;
          c.pc_w = 1'b1;
        end
      S_LOAD_A: begin
        c.mx = MX_SRC;
        c.a_w = 1'b1;
      end
      S_LOAD_B: begin
        c.mx = MX_DST;
        c.b_w = 1'b1;
      end
      S_EXEC: begin
        c.mx = cop_q == COP_CMP ? MX_PC : MX_DST;
        c.alu = cop_q == COP_ADD ? ALU_ADD : cop_q == COP_CMP ? ALU_SUB : ALU_PASS_A;
        c.le = cop_q != COP_CMP;
        c.fz_w = 1'b1;
      end
      S_IN_WAIT: begin
        c.mx = MX_DST;
        c.in_req = 1'b1;
        c.le = bus.in_valid;
        c.mx_memio = bus.in_valid;
      end
      S_OUT_WAIT: begin
        c.mx = MX_DST;
        c.out_valid = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end
  assign {bus.mx1, bus.mx0} = c.mx;
  assign {bus.alu_op1, bus.alu_op0} = c.alu;
  assign bus.le = c.le;
  assign bus.pc_w = c.pc_w;
  assign bus.ir_w = c.ir_w;
  assign bus.a_w = c.a_w;
  assign bus.b_w = c.b_w;
  assign bus.fz_w = c.fz_w;
  assign bus.mx_memio = c.mx_memio;
  assign bus.in_req = c.in_req;
  assign bus.out_valid = c.out_valid;
  assign bus.halted = c.halted;
endmodule

// File: tb/tb_uc.sv
// tb_uc: randomized self-checking bench for uc against a per-instruction cycle-sequence model
module tb_uc;
  localparam logic [9:0] F_LE  = 10'b1000000000;
  localparam logic [9:0] F_PC  = 10'b0100000000;
  localparam logic [9:0] F_IR  = 10'b0010000000;
  localparam logic [9:0] F_A   = 10'b0001000000;
  localparam logic [9:0] F_B   = 10'b0000100000;
  localparam logic [9:0] F_FZ  = 10'b0000010000;
  localparam logic [9:0] F_MM  = 10'b0000001000;
  localparam logic [9:0] F_INR = 10'b0000000100;
  localparam logic [9:0] F_OV  = 10'b0000000010;
  localparam logic [9:0] F_H   = 10'b0000000001;
  typedef struct {
    logic [3:0] cop;
    logic fz, iv, orr;
    logic [13:0] exp;
  } cyc_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit skip;
  cyc_t q[$];
  logic [13:0] got;
  uc_if bus();
  uc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.mx1, bus.mx0, bus.alu_op1, bus.alu_op0, bus.le, bus.pc_w, bus.ir_w,
                bus.a_w, bus.b_w, bus.fz_w, bus.mx_memio, bus.in_req, bus.out_valid, bus.halted};

  function automatic logic [13:0] w(input logic [1:0] mx, input logic [1:0] alu, input logic [9:0] f);
    return {mx, alu, f};
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [3:0] rc();
    return 4'($urandom);
  endfunction
  task automatic push(input logic [3:0] op, input logic fz, input logic iv, input logic orr, input logic [13:0] e);
    cyc_t c;
    c.cop = op; c.fz = fz; c.iv = iv; c.orr = orr; c.exp = e;
    q.push_back(c);
  endtask

  // Expected per-cycle control words for one instruction; opcode is only
  // presented while it is live in IR (FETCH/DECODE), garbage afterwards.
  task automatic plan(input logic [3:0] op, input logic f, input int n);
    if (!skip) push(op, rb(), rb(), rb(), w(2'd0, 2'd0, F_IR | F_PC));
    skip = 1'b0;
    if (op == 4'h3) begin
      push(op, f, rb(), rb(), f ? w(2'd3, 2'd0, F_IR | F_PC) : 14'd0);
      skip = f;
    end else if (op <= 4'h2) begin
      push(op, rb(), rb(), rb(), 14'd0);
      push(rc(), rb(), rb(), rb(), w(2'd2, 2'd0, F_A));
      if (op != 4'h2) push(rc(), rb(), rb(), rb(), w(2'd3, 2'd0, F_B));
      push(rc(), rb(), rb(), rb(), op == 4'h0 ? w(2'd3, 2'd0, F_LE | F_FZ) :
                                   op == 4'h1 ? w(2'd0, 2'd1, F_FZ) : w(2'd3, 2'd2, F_LE | F_FZ));
    end else if (op == 4'h4) begin
      push(op, rb(), rb(), rb(), 14'd0);
      repeat (n) push(rc(), rb(), 1'b0, rb(), w(2'd3, 2'd0, F_INR));
      push(rc(), rb(), 1'b1, rb(), w(2'd3, 2'd0, F_INR | F_LE | F_MM));
    end else if (op == 4'h5) begin
      push(op, rb(), rb(), rb(), 14'd0);
      repeat (n) push(rc(), rb(), rb(), 1'b0, w(2'd3, 2'd0, F_OV));
      push(rc(), rb(), rb(), 1'b1, w(2'd3, 2'd0, F_OV));
    end else begin
      push(op, rb(), rb(), rb(), 14'd0);
      repeat (n) push(rc(), rb(), rb(), rb(), w(2'd0, 2'd0, F_H));
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    skip = 1'b0;
    push(rc(), rb(), rb(), rb(), 14'd0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.cop = 4'h0; bus.fz = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #2;
    n_cmp++;
    if (got !== 14'd0) begin n_bad++; $display("FAIL reset_async: got %b want %b", got, 14'd0); end
    repeat (3) begin
      @(posedge clk);
      #1 bus.cop = rc();
      n_cmp++;
      if (got !== 14'd0) begin n_bad++; $display("FAIL reset_held: got %b want %b", got, 14'd0); end
    end
  endtask

  task automatic test_add();
    cyc_t c;
    apply_reset();
    plan(4'h0, 1'b0, 0);
    plan(4'h0, 1'b0, 0);
    plan(4'h1, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(negedge clk);
      n_cmp++;
      if (got !== c.exp) begin n_bad++; $display("FAIL add_seq: got %b want %b", got, c.exp); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_beq();
    cyc_t c;
    apply_reset();
    plan(4'h3, 1'b1, 0);
    plan(4'h0, 1'b0, 0);
    plan(4'h3, 1'b0, 0);
    plan(4'h2, 1'b0, 0);
    plan(4'h3, 1'b1, 0);
    plan(4'h3, 1'b1, 0);
    plan(4'h2, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(negedge clk);
      n_cmp++;
      if (got !== c.exp) begin n_bad++; $display("FAIL beq_seq: got %b want %b", got, c.exp); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_io();
    cyc_t c;
    apply_reset();
    plan(4'h4, 1'b0, 3);
    plan(4'h5, 1'b0, 2);
    plan(4'h4, 1'b0, 0);
    plan(4'h5, 1'b0, 0);
    plan(4'h1, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(negedge clk);
      n_cmp++;
      if (got !== c.exp) begin n_bad++; $display("FAIL io_seq: got %b want %b", got, c.exp); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    cyc_t c;
    apply_reset();
    plan(4'hF, 1'b0, 10);
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(negedge clk);
      n_cmp++;
      if (got !== c.exp) begin n_bad++; $display("FAIL halt_seq: got %b want %b", got, c.exp); end
      @(posedge clk);
      #1;
    end
    apply_reset();
    plan(4'h2, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(negedge clk);
      n_cmp++;
      if (got !== c.exp) begin n_bad++; $display("FAIL halt_exit: got %b want %b", got, c.exp); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_abort();
    cyc_t c;
    apply_reset();
    plan(4'h0, 1'b0, 0);
    while (q.size() > 1) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(posedge clk);
      #1;
    end
    c = q.pop_front();
    bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
    #2;
    n_cmp++;
    if (got !== c.exp) begin n_bad++; $display("FAIL exec_before_rst: got %b want %b", got, c.exp); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got !== 14'd0) begin n_bad++; $display("FAIL exec_rst_now: got %b want %b", got, 14'd0); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (got !== 14'd0) begin n_bad++; $display("FAIL exec_rst_edge: got %b want %b", got, 14'd0); end
    apply_reset();
    plan(4'h4, 1'b0, 6);
    while (q.size() > 4) begin
      c = q.pop_front();
      bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (got !== 14'd0) begin n_bad++; $display("FAIL in_wait_rst: got %b want %b", got, 14'd0); end
  endtask

  task automatic test_random();
    cyc_t c;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      plan(4'($urandom_range(0, 5)), rb(), int'($urandom_range(0, 3)));
      while (q.size() > 0) begin
        c = q.pop_front();
        bus.cop = c.cop; bus.fz = c.fz; bus.in_valid = c.iv; bus.out_ready = c.orr;
        @(negedge clk);
        n_cmp++;
        if (got !== c.exp) begin n_bad++; $display("FAIL random_seq %0d: got %b want %b", i, got, c.exp); end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bus.cop = 4'h0; bus.fz = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_beq();
    test_io();
    test_halt();
    test_async_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
